// File: rtl/trng_postproc_if.sv
// Stream interface of the TRNG post-processor: raw sample input, byte output and status.
// The slave modport is the post-processor; the master modport is the sampler/consumer side.
interface trng_postproc_if;
    logic       raw_bit;
    logic       raw_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       health_fail;
    logic [7:0] drop_cnt;

    modport master (
        output raw_bit, raw_valid, out_ready,
        input  out_byte, out_valid, health_fail, drop_cnt
    );

    modport slave (
        input  raw_bit, raw_valid, out_ready,
        output out_byte, out_valid, health_fail, drop_cnt
    );
endinterface

// File: rtl/trng_postproc.sv
// Von Neumann debiaser, repetition-count health test and LSB-first byte packer for RO samples.
// Define TRNG_APT_EN to also build the adaptive-proportion health test.
module trng_postproc #(
    parameter int unsigned REP_CUTOFF = 16,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    trng_postproc_if.slave    bus
);
    typedef enum logic [1:0] {StPairA, StPairB, StFail} state_e;

    state_e     state_q, state_d;
    logic       a_q, a_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       last_q, last_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       out_valid_q, out_valid_d;
    logic       fail_q, fail_d;
    logic [7:0] drop_q, drop_d;
    logic       sample, emit, byte_done, rep_trip, apt_trip;

    assign sample = bus.raw_valid && (state_q != StFail);

`ifdef TRNG_APT_EN
    localparam int unsigned AptW = $clog2(APT_WINDOW + 1);

    logic [AptW-1:0] apt_pos_q, apt_pos_d, apt_cnt_q, apt_cnt_d;
    logic            apt_ref_q, apt_ref_d;

    always_comb begin
        apt_pos_d = apt_pos_q;
        apt_cnt_d = apt_cnt_q;
        apt_ref_d = apt_ref_q;
        if (sample) begin
            if (apt_pos_q == '0) begin
                apt_ref_d = bus.raw_bit;
                apt_cnt_d = AptW'(1);
                apt_pos_d = AptW'(1);
            end else begin
                if (bus.raw_bit == apt_ref_q) apt_cnt_d = apt_cnt_q + AptW'(1);
                apt_pos_d = (apt_pos_q == AptW'(APT_WINDOW - 1)) ? '0 : apt_pos_q + AptW'(1);
            end
        end
    end

    assign apt_trip = sample && (apt_cnt_d == AptW'(APT_CUTOFF));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            apt_pos_q <= '0;
            apt_cnt_q <= '0;
            apt_ref_q <= 1'b0;
        end else begin
            apt_pos_q <= apt_pos_d;
            apt_cnt_q <= apt_cnt_d;
            apt_ref_q <= apt_ref_d;
        end
    end
`else
    logic unused_apt_params;
    assign unused_apt_params = ^{APT_WINDOW, APT_CUTOFF};
    assign apt_trip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        last_d      = last_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        fail_d      = fail_q;
        drop_d      = drop_q;
        emit        = 1'b0;

        // Counter is 0 only straight after reset, so the first sample always lands on 1.
        if (sample) begin
            last_d    = bus.raw_bit;
            rep_cnt_d = (rep_cnt_q == 8'd0 || bus.raw_bit != last_q) ? 8'd1 : rep_cnt_q + 8'd1;
        end
        rep_trip = sample && (rep_cnt_d == 8'(REP_CUTOFF));

        unique case (state_q)
            StPairA: begin
                if (sample) begin
                    a_d     = bus.raw_bit;
                    state_d = StPairB;
                end
            end
            StPairB: begin
                if (sample) begin
                    state_d = StPairA;
                    emit    = (bus.raw_bit != a_q);
                end
            end
            StFail:  state_d = StFail;
            default: state_d = StPairA;
        endcase

        if (emit) begin
            shift_d   = {a_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        byte_done = emit && (bit_cnt_q == 3'd7);

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (byte_done) begin
            if (!out_valid_q || bus.out_ready) begin
                out_byte_d  = shift_d;
                out_valid_d = 1'b1;
            end else if (drop_q != 8'hff) begin
                drop_d = drop_q + 8'd1;
            end
        end

        // A health failure overrides any byte completing or being dropped this cycle.
        if (rep_trip || apt_trip) begin
            state_d     = StFail;
            fail_d      = 1'b1;
            out_valid_d = 1'b0;
            out_byte_d  = 8'h00;
            drop_d      = drop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StPairA;
            a_q         <= 1'b0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            rep_cnt_q   <= 8'd0;
            last_q      <= 1'b0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            fail_q      <= 1'b0;
            drop_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            last_q      <= last_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            fail_q      <= fail_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.out_byte    = out_byte_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.health_fail = fail_q;
    assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_trng_postproc.sv
// Directed self-checking bench for trng_postproc; define TRNG_APT_EN to exercise the APT test.
module tb_trng_postproc;
`ifdef TRNG_APT_EN
    localparam int unsigned RepCutoff = 255;
`else
    localparam int unsigned RepCutoff = 16;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    trng_postproc_if bus();

    trng_postproc #(
        .REP_CUTOFF (RepCutoff),
        .APT_WINDOW (64),
        .APT_CUTOFF (48)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic b);
        @(negedge clk);
        bus.raw_bit   = b;
        bus.raw_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.raw_valid = 1'b0;
    endtask

    // Sends s[n-1] first, down to s[0].
    task automatic send_seq(input logic [31:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) send(s[i]);
    endtask

    // Each byte bit b is sent as the pair (b, ~b), LSB first.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send(v[i]);
            send(~v[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.raw_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.raw_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_byte !== 8'h00) begin
            failures++; $display("FAIL reset_byte got=%h exp=00", bus.out_byte);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.health_fail !== 1'b0) begin
            failures++; $display("FAIL reset_health got=%b exp=0", bus.health_fail);
        end
        checks++;
        if (bus.drop_cnt !== 8'h00) begin
            failures++; $display("FAIL reset_drop got=%h exp=00", bus.drop_cnt);
        end
    endtask

    // Partial pair/byte before reset must leave no trace in the next byte.
    task automatic test_reset_mid_byte();
        do_reset();
        send_seq(32'b10011, 5);
        do_reset();
        send_byte(8'h4d);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h4d) begin
            failures++;
            $display("FAIL mid_reset got=%b/%h exp=1/4d", bus.out_valid, bus.out_byte);
        end
        consume();
    endtask

    // Pairs 10,01,10,10,01,01,10,01 give bits 1,0,1,1,0,0,1,0 -> LSB-first 0x4D.
    task automatic test_basic();
        do_reset();
        send_seq(32'b1001101001011001, 16);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_early got=%b exp=0", bus.out_valid);
        end
        idle();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid);
        end
        checks++;
        if (bus.out_byte !== 8'h4d) begin
            failures++; $display("FAIL basic_byte got=%h exp=4d", bus.out_byte);
        end
        checks++;
        if (bus.health_fail !== 1'b0) begin
            failures++; $display("FAIL basic_health got=%b exp=0", bus.health_fail);
        end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_consume got=%b exp=0", bus.out_valid);
        end
    endtask

    // Same pairs with 00/11 pairs interleaved: 10,00,01,11,10,10,00,01,01,11,10,01.
    task automatic test_discard();
        do_reset();
        send_seq(32'b100001111010000101111001, 24);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h4d) begin
            failures++;
            $display("FAIL discard got=%b/%h exp=1/4d", bus.out_valid, bus.out_byte);
        end
        consume();
    endtask

    task automatic test_backpressure();
        do_reset();
        send_byte(8'h4d);
        send_byte(8'hff);
        send_byte(8'h00);
        idle();
        checks++;
        if (bus.out_byte !== 8'h4d) begin
            failures++; $display("FAIL bp_held got=%h exp=4d", bus.out_byte);
        end
        checks++;
        if (bus.drop_cnt !== 8'd2) begin
            failures++; $display("FAIL bp_drop got=%0d exp=2", bus.drop_cnt);
        end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_after got=%b exp=0", bus.out_valid);
        end
    endtask

    // 0xA5 completes on the very edge that transfers the held 0x4D.
    task automatic test_back_to_back();
        logic [7:0] v;
        do_reset();
        send_byte(8'h4d);
        v = 8'ha5;
        for (int i = 0; i < 7; i++) begin
            send(v[i]);
            send(~v[i]);
        end
        send(v[7]);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h4d) begin
            failures++;
            $display("FAIL b2b_before got=%b/%h exp=1/4d", bus.out_valid, bus.out_byte);
        end
        bus.out_ready = 1'b1;
        bus.raw_bit   = ~v[7];
        bus.raw_valid = 1'b1;
        @(negedge clk);
        bus.raw_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'ha5) begin
            failures++;
            $display("FAIL b2b_new got=%b/%h exp=1/a5", bus.out_valid, bus.out_byte);
        end
        checks++;
        if (bus.drop_cnt !== 8'd0) begin
            failures++; $display("FAIL b2b_drop got=%0d exp=0", bus.drop_cnt);
        end
        consume();
    endtask

`ifndef TRNG_APT_EN
    task automatic test_rep_fail();
        do_reset();
        send_byte(8'h4d);
        send_byte(8'ha5);   // dropped; last raw sample is 0
        for (int i = 0; i < 16; i++) send(1'b1);
        checks++;
        if (bus.health_fail !== 1'b0) begin
            failures++; $display("FAIL rep_15 got=%b exp=0", bus.health_fail);
        end
        idle();
        checks++;
        if (bus.health_fail !== 1'b1) begin
            failures++; $display("FAIL rep_16 got=%b exp=1", bus.health_fail);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL rep_valid got=%b exp=0", bus.out_valid);
        end
        send_byte(8'h4d);
        send_byte(8'ha5);
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rep_frozen got=%b/%0d exp=0/1", bus.out_valid, bus.drop_cnt);
        end
        do_reset();
        checks++;
        if (bus.health_fail !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00 ||
            bus.drop_cnt !== 8'h00) begin
            failures++;
            $display("FAIL rep_reset got=%b/%b/%h/%h exp=0/0/00/00", bus.health_fail,
                     bus.out_valid, bus.out_byte, bus.drop_cnt);
        end
        send_byte(8'ha5);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'ha5) begin
            failures++;
            $display("FAIL rep_resume got=%b/%h exp=1/a5", bus.out_valid, bus.out_byte);
        end
        consume();
    endtask
`else
    // 16 blocks of 1110 give 48 ones in a 64-sample window; last block 1100 gives 47.
    task automatic test_apt();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_seq(32'b1110, 4);
        send_seq(32'b1100, 4);
        idle();
        checks++;
        if (bus.health_fail !== 1'b0) begin
            failures++; $display("FAIL apt_47 got=%b exp=0", bus.health_fail);
        end
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_seq(32'b1110, 4);
        idle();
        checks++;
        if (bus.health_fail !== 1'b1) begin
            failures++; $display("FAIL apt_48 got=%b exp=1", bus.health_fail);
        end
        bus.out_ready = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b1;
        bus.raw_bit   = 1'b0;
        bus.raw_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_reset_mid_byte();
        test_basic();
        test_discard();
        test_backpressure();
        test_back_to_back();
`ifndef TRNG_APT_EN
        test_rep_fail();
`else
        test_apt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
